pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipeline_pkg.sv | 13 +
 rtl/pipe_slot.sv | 41 ++++
 rtl/pipe_stage_reg.sv | 187 ++++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg -- shared types and constants for the pipeline stage register.
// The stage FSM state encoding doubles as the occupancy count (0, 1 or 2 entries).
package pipeline_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,  // no entry held
        HALF  = 2'd1,  // main slot holds the presented entry
        FULL  = 2'd2   // main slot presented, skid slot holds the next entry
    } stage_state_t;

    localparam int STALL_CNT_W = 32;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot -- one storage slot of the stage: valid flag, control and payload.
// load has priority over clr. clr always empties the slot and zeroes control;
// the payload is zeroed only when clr_data is also set, otherwise it is held.
module pipe_slot #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clr,
    input  logic              clr_data,
    input  logic [CTRL_W-1:0] load_ctrl,
    input  logic [DATA_W-1:0] load_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    // Slot register: capture on load, empty on clr, everything zero in reset.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the payload is reset as well, because out_data must read zero while rst is asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= load_ctrl;
            data  <= load_data;
        end else if (clr) begin
            valid <= 1'b0;
            ctrl  <= '0;
            if (clr_data) begin
                data <= '0;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- valid/ready pipeline stage register with flush and stall counter.
// Build option PIPE_STAGE_SKID_EN: adds a skid slot so in_ready is registered
// (state != FULL) with no combinational path from out_ready. Without it the stage
// holds at most one entry and in_ready = !out_valid || out_ready.
// Entries are presented straight from the main slot, so out_* are registered.
module pipe_stage_reg
    import pipeline_pkg::*;
#(
    parameter int DATA_W   = 96,
    parameter int CTRL_W   = 16,
    parameter int CLR_DATA = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [DATA_W-1:0]      out_data,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    stage_state_t           state_q;
    stage_state_t           state_d;
    logic                   in_xfer;
    logic                   out_xfer;
    logic                   main_load;
    logic                   main_clr;
    logic                   main_clr_data;
    logic [CTRL_W-1:0]      main_ctrl_in;
    logic [DATA_W-1:0]      main_data_in;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_nxt;

`ifdef PIPE_STAGE_SKID_EN
    logic                   skid_load;
    logic                   skid_clr;
    logic                   skid_valid;
    logic [CTRL_W-1:0]      skid_ctrl;
    logic [DATA_W-1:0]      skid_data;
    logic                   in_ready_q;

    assign in_ready     = in_ready_q;
    // Leaving FULL refills main from skid; every other load comes from upstream.
    assign main_ctrl_in = (state_q == FULL) ? skid_ctrl : in_ctrl;
    assign main_data_in = (state_q == FULL) ? skid_data : in_data;
`else
    logic                   ready_en_q;

    // ready_en_q keeps in_ready low during reset and until the first edge after it.
    assign in_ready     = ready_en_q && (!out_valid || out_ready);
    assign main_ctrl_in = in_ctrl;
    assign main_data_in = in_data;
`endif

    // flush outranks both transfers: the offered entry is dropped, nothing leaves.
    assign in_xfer  = in_valid && in_ready && !flush;
    assign out_xfer = out_valid && out_ready && !flush;

    // Next-state and slot-control decode from the current state and this cycle's transfers.
    // NOTE: every signal written here gets a default first, so no path infers a latch.
    always_comb begin
        state_d       = state_q;
        main_load     = 1'b0;
        main_clr      = 1'b0;
        main_clr_data = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        skid_load     = 1'b0;
        skid_clr      = 1'b0;
`endif
        if (flush) begin
            state_d       = EMPTY;
            main_clr      = 1'b1;
            main_clr_data = (CLR_DATA != 0);
`ifdef PIPE_STAGE_SKID_EN
            skid_clr      = 1'b1;
`endif
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        main_load = 1'b1;
                        state_d   = HALF;
                    end
                end
                HALF: begin
                    if (in_xfer && out_xfer) begin
                        main_load = 1'b1;
                    end else if (out_xfer) begin
                        main_clr = 1'b1;
                        state_d  = EMPTY;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (in_xfer) begin
                        skid_load = 1'b1;
                        state_d   = FULL;
`endif
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                FULL: begin
                    if (out_xfer && skid_valid) begin
                        main_load = 1'b1;
                        skid_clr  = 1'b1;
                        state_d   = HALF;
                    end
                end
`endif
                default: state_d = EMPTY;
            endcase
        end
    end

    // Stage FSM with its registered ready output; reset overrides flush and transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
`ifdef PIPE_STAGE_SKID_EN
            in_ready_q <= 1'b0;
`else
            ready_en_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
`ifdef PIPE_STAGE_SKID_EN
            in_ready_q <= (state_d != FULL);
`else
            ready_en_q <= 1'b1;
`endif
        end
    end

    // Backpressure counter: counts presented-but-not-taken cycles, saturates, ignores flush.
    assign stall_cnt_nxt = (out_valid && !out_ready && (stall_cnt_q != '1))
                           ? stall_cnt_q + STALL_CNT_W'(1) : stall_cnt_q;

    // Stall counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_nxt;
        end
    end

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk       (clk),
        .rst       (rst),
        .load      (main_load),
        .clr       (main_clr),
        .clr_data  (main_clr_data),
        .load_ctrl (main_ctrl_in),
        .load_data (main_data_in),
        .valid     (out_valid),
        .ctrl      (out_ctrl),
        .data      (out_data)
    );

`ifdef PIPE_STAGE_SKID_EN
    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .clr       (skid_clr),
        .clr_data  (skid_clr),
        .load_ctrl (in_ctrl),
        .load_data (in_data),
        .valid     (skid_valid),
        .ctrl      (skid_ctrl),
        .data      (skid_data)
    );
`endif

    assign occupancy = 2'(state_q);
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg -- scoreboard bench for pipe_stage_reg (default parameters).
// Honours PIPE_STAGE_SKID_EN: expected occupancy limit and ready behaviour follow the build.
module tb_pipe_stage_reg;

    localparam int DATA_W      = 96;
    localparam int CTRL_W      = 16;
    localparam int STALL_CNT_W = 32;
`ifdef PIPE_STAGE_SKID_EN
    localparam bit         SKID    = 1'b1;
    localparam logic [1:0] MAX_OCC = 2'd2;
`else
    localparam bit         SKID    = 1'b0;
    localparam logic [1:0] MAX_OCC = 2'd1;
`endif

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic                   clk;
    logic                   rst;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [CTRL_W-1:0]      in_ctrl;
    logic [DATA_W-1:0]      in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [CTRL_W-1:0]      out_ctrl;
    logic [DATA_W-1:0]      out_data;
    logic [1:0]             occupancy;
    logic [STALL_CNT_W-1:0] stall_cnt;

    entry_t                 q[$];
    int                     vectors     = 0;
    int                     miscompares = 0;
    int                     in_cnt      = 0;
    int                     out_cnt     = 0;
    logic                   ready_en    = 1'b0;
    logic                   last_in_acc = 1'b0;
    logic                   last_in_rdy = 1'b0;
    logic [STALL_CNT_W-1:0] exp_stall   = '0;

    pipe_stage_reg dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at 1000000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input entry_t e);
        in_valid = 1'b1;
        in_ctrl  = e.ctrl;
        in_data  = e.data;
    endtask

    function automatic entry_t rand_entry();
        entry_t e;
        e.ctrl = CTRL_W'($urandom());
        e.data = {$urandom(), $urandom(), $urandom()};
        return e;
    endfunction

    // One clock: at the falling edge check state against the scoreboard and
    // record the transfers of the coming rising edge; return 1 ns after it.
    task automatic tick();
        entry_t     e;
        logic [1:0] occ_exp;
        logic       rdy_exp;
        logic       stall_now;
        @(negedge clk);
        occ_exp = 2'(q.size());
        vectors++;
        if (occupancy !== occ_exp) begin
            miscompares++;
            $display("FAIL occupancy: got %0d expected %0d", occupancy, occ_exp);
        end
        vectors++;
        if (out_valid !== (q.size() != 0)) begin
            miscompares++;
            $display("FAIL out_valid: got %b expected %b", out_valid, q.size() != 0);
        end
        if (!out_valid) begin
            vectors++;
            if (out_ctrl !== '0) begin
                miscompares++;
                $display("FAIL bubble_ctrl: got %h expected 0", out_ctrl);
            end
        end
        rdy_exp = ready_en && (SKID ? (q.size() < 2) : ((q.size() == 0) || out_ready));
        vectors++;
        if (in_ready !== rdy_exp) begin
            miscompares++;
            $display("FAIL in_ready: got %b expected %b", in_ready, rdy_exp);
        end
        vectors++;
        if (stall_cnt !== exp_stall) begin
            miscompares++;
            $display("FAIL stall_cnt: got %h expected %h", stall_cnt, exp_stall);
        end
        stall_now   = (q.size() != 0) && !out_ready;
        last_in_acc = 1'b0;
        last_in_rdy = in_ready;
        if (rst || flush) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_output: got %h/%h expected none", out_ctrl, out_data);
                end else begin
                    e = q.pop_front();
                    out_cnt++;
                    if (out_ctrl !== e.ctrl || out_data !== e.data) begin
                        miscompares++;
                        $display("FAIL output_order: got %h/%h expected %h/%h",
                                 out_ctrl, out_data, e.ctrl, e.data);
                    end
                end
            end
            if (in_valid && in_ready) begin
                e.ctrl = in_ctrl;
                e.data = in_data;
                q.push_back(e);
                in_cnt++;
                last_in_acc = 1'b1;
            end
        end
        if (rst) exp_stall = '0;
        else if (stall_now && exp_stall != '1) exp_stall = exp_stall + 1'b1;
        @(posedge clk);
        ready_en = !rst;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive('{ctrl: 16'hFFFF, data: {3{32'hDEAD_BEEF}}});
        tick();
        tick();
        vectors += 6;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        if (out_ctrl  !== '0)   begin miscompares++; $display("FAIL reset_out_ctrl: got %h expected 0", out_ctrl); end
        if (out_data  !== '0)   begin miscompares++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        if (occupancy !== 2'd0) begin miscompares++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        if (stall_cnt !== '0)   begin miscompares++; $display("FAIL reset_stall_cnt: got %h expected 0", stall_cnt); end
        if (in_ready  !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL ready_before_edge: got %b expected 0", in_ready); end
        tick();
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_edge: got %b expected 1", in_ready); end
    endtask

    task automatic test_first_transfer();
        out_ready = 1'b1;
        drive('{ctrl: 16'h00A5, data: 96'h1});
        tick();
        in_valid = 1'b0;
        vectors += 5;
        if (out_valid !== 1'b1)    begin miscompares++; $display("FAIL first_valid: got %b expected 1", out_valid); end
        if (out_data  !== 96'h1)   begin miscompares++; $display("FAIL first_data: got %h expected 1", out_data); end
        if (out_ctrl  !== 16'h00A5) begin miscompares++; $display("FAIL first_ctrl: got %h expected 00a5", out_ctrl); end
        if (occupancy !== 2'd1)    begin miscompares++; $display("FAIL first_occupancy: got %0d expected 1", occupancy); end
        if (stall_cnt !== '0)      begin miscompares++; $display("FAIL first_stall: got %h expected 0", stall_cnt); end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL first_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        entry_t                 a;
        entry_t                 b;
        logic [STALL_CNT_W-1:0] start;
        int                     out_start;
        a.ctrl = 16'h0A0A; a.data = 96'hAAAA_0000_0000_0000_0000_000A;
        b.ctrl = 16'h0B0B; b.data = 96'hBBBB_0000_0000_0000_0000_000B;
        start     = exp_stall;
        out_start = out_cnt;
        out_ready = 1'b0;
        drive(a);
        tick();
        vectors++;
        if (last_in_acc !== 1'b1) begin miscompares++; $display("FAIL bp_accept_a: got %b expected 1", last_in_acc); end
        drive(b);
        tick();
        vectors++;
        if (last_in_acc !== SKID) begin miscompares++; $display("FAIL bp_accept_b: got %b expected %b", last_in_acc, SKID); end
        if (last_in_acc) in_valid = 1'b0;
        tick();
        vectors += 5;
        if (occupancy !== MAX_OCC) begin miscompares++; $display("FAIL bp_occupancy: got %0d expected %0d", occupancy, MAX_OCC); end
        if (in_ready  !== 1'b0)    begin miscompares++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
        if (out_data  !== a.data)  begin miscompares++; $display("FAIL bp_head_data: got %h expected %h", out_data, a.data); end
        if (out_ctrl  !== a.ctrl)  begin miscompares++; $display("FAIL bp_head_ctrl: got %h expected %h", out_ctrl, a.ctrl); end
        if (stall_cnt !== start + 32'd2) begin miscompares++; $display("FAIL bp_stall: got %h expected %h", stall_cnt, start + 32'd2); end
        out_ready = 1'b1;
        for (int i = 0; i < 6 && (in_valid || q.size() != 0); i++) begin
            tick();
            if (last_in_acc) in_valid = 1'b0;
        end
        vectors += 3;
        if (out_cnt - out_start != 2) begin miscompares++; $display("FAIL bp_drain_count: got %0d expected 2", out_cnt - out_start); end
        if (q.size() != 0) begin miscompares++; $display("FAIL bp_drain_timeout: got %0d pending expected 0", q.size()); end
        if (stall_cnt !== start + 32'd2) begin miscompares++; $display("FAIL bp_stall_final: got %h expected %h", stall_cnt, start + 32'd2); end
    endtask

    task automatic test_flush();
        int out_start;
        out_ready = 1'b0;
        drive('{ctrl: 16'h1111, data: 96'h111});
        tick();
        if (last_in_acc) in_valid = 1'b0;
        drive('{ctrl: 16'h2222, data: 96'h222});
        tick();
        if (last_in_acc) in_valid = 1'b0;
        vectors++;
        if (occupancy !== MAX_OCC) begin miscompares++; $display("FAIL flush_prefill: got %0d expected %0d", occupancy, MAX_OCC); end
        drive('{ctrl: 16'h3333, data: 96'h333});
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        vectors += 5;
        if (occupancy !== 2'd0) begin miscompares++; $display("FAIL flush_occupancy: got %0d expected 0", occupancy); end
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
        if (out_ctrl  !== '0)   begin miscompares++; $display("FAIL flush_ctrl: got %h expected 0", out_ctrl); end
        if (out_data  !== '0)   begin miscompares++; $display("FAIL flush_data: got %h expected 0", out_data); end
        if (in_ready  !== 1'b1) begin miscompares++; $display("FAIL flush_ready: got %b expected 1", in_ready); end
        out_ready = 1'b1;
        out_start = out_cnt;
        repeat (3) tick();
        vectors++;
        if (out_cnt != out_start) begin miscompares++; $display("FAIL flush_leak: got %0d outputs expected 0", out_cnt - out_start); end
    endtask

    task automatic test_back_to_back();
        int in_start;
        int out_start;
        int rdy_bad;
        int occ_bad;
        in_start  = in_cnt;
        out_start = out_cnt;
        rdy_bad   = 0;
        occ_bad   = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            drive('{ctrl: CTRL_W'(i), data: {32'(i), $urandom(), $urandom()}});
            tick();
            if (last_in_rdy !== 1'b1) rdy_bad++;
            if (occupancy !== 2'd1) occ_bad++;
        end
        in_valid = 1'b0;
        tick();
        vectors += 5;
        if (in_cnt - in_start != 100)   begin miscompares++; $display("FAIL stream_accepted: got %0d expected 100", in_cnt - in_start); end
        if (rdy_bad != 0)               begin miscompares++; $display("FAIL stream_ready_drop: got %0d cycles low expected 0", rdy_bad); end
        if (occ_bad != 0)               begin miscompares++; $display("FAIL stream_not_half: got %0d cycles expected 0", occ_bad); end
        if (out_cnt - out_start != 100) begin miscompares++; $display("FAIL stream_delivered: got %0d expected 100", out_cnt - out_start); end
        if (out_valid !== 1'b0)         begin miscompares++; $display("FAIL stream_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || last_in_acc) begin
                drive(rand_entry());
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6 && q.size() != 0; i++) tick();
        vectors++;
        if (q.size() != 0) begin miscompares++; $display("FAIL random_drain: got %0d pending expected 0", q.size()); end
    endtask

    task automatic test_saturate();
        out_ready = 1'b0;
        drive(rand_entry());
        tick();
        if (last_in_acc) in_valid = 1'b0;
        drive(rand_entry());
        tick();
        in_valid = 1'b0;
        force dut.stall_cnt_nxt = 32'hFFFF_FFFE;
        tick();
        release dut.stall_cnt_nxt;
        exp_stall = 32'hFFFF_FFFE;
        vectors++;
        if (stall_cnt !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL sat_preload: got %h expected fffffffe", stall_cnt); end
        tick();
        vectors++;
        if (stall_cnt !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL sat_reach: got %h expected ffffffff", stall_cnt); end
        tick();
        tick();
        vectors++;
        if (stall_cnt !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL sat_hold: got %h expected ffffffff", stall_cnt); end
        rst = 1'b1; flush = 1'b1; out_ready = 1'b1;
        drive(rand_entry());
        tick();
        vectors += 5;
        if (stall_cnt !== '0)   begin miscompares++; $display("FAIL sat_reset_stall: got %h expected 0", stall_cnt); end
        if (occupancy !== 2'd0) begin miscompares++; $display("FAIL sat_reset_occ: got %0d expected 0", occupancy); end
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL sat_reset_valid: got %b expected 0", out_valid); end
        if (out_data  !== '0)   begin miscompares++; $display("FAIL sat_reset_data: got %h expected 0", out_data); end
        if (in_ready  !== 1'b0) begin miscompares++; $display("FAIL sat_reset_ready: got %b expected 0", in_ready); end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        tick();
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL sat_ready_return: got %b expected 1", in_ready); end
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_first_transfer();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_random();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
